fifo_write_arbiter: RTL and testbench

Round-robin arbiter that shares the single write port of a `FIFO` instance among `NUM_REQ` independent producers, such as audio channel sample generators or PPU pixel writers, each with a valid/ready handshake. It registers the winning beat onto the FIFO's `wr_en`/`data_in` and tracks FIFO space from `occupancy_out`, so no write is issued into a full FIFO. It sits directly in front of one `FIFO` instance and is the only driver of that instance's write side.

---
 rtl/fifo_write_arbiter.sv | 167 ++++++++++++++++
 tb/tb_fifo_write_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_write_arbiter.sv
// rtl/fifo_write_arbiter.sv - round-robin arbiter driving one FIFO write port
// Optional per-grant bursting is enabled by defining FIFO_ARB_BURST_EN.
module fifo_write_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 8,
    parameter int BURST_LEN = 4
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic [NUM_REQ-1:0]         req_valid_in,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data_in,
    output logic [NUM_REQ-1:0]         req_ready_out,
    output logic                       fifo_wr_en_out,
    output logic [WIDTH-1:0]           fifo_data_out,
    input  logic [$clog2(DEPTH):0]     fifo_occupancy_in,
    input  logic                       fifo_full_in,
    output logic [$clog2(NUM_REQ)-1:0] grant_id_out,
    output logic                       grant_valid_out
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int SW = $clog2(DEPTH) + 2;

    if (NUM_REQ < 2 || BURST_LEN < 1) begin : g_param_check
        $error("fifo_write_arbiter: NUM_REQ must be >= 2 and BURST_LEN >= 1");
    end

    logic             wr_en_q, wr_en_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [IW-1:0]    gid_q, gid_d;
    logic [IW-1:0]    rr_ptr_q, rr_ptr_d;

    logic             space_ok;
    logic             win_found;
    logic [IW-1:0]    win_idx;
    logic             cand_found;
    logic [IW-1:0]    cand_idx;
    logic             accept;

    function automatic logic [IW-1:0] ptr_inc(input logic [IW-1:0] p);
        return (p == IW'(NUM_REQ - 1)) ? '0 : p + 1'b1;
    endfunction

    // The beat already registered for the FIFO counts as occupied space.
    assign space_ok = ((SW'(fifo_occupancy_in) + SW'(wr_en_q)) < SW'(DEPTH)) && !fifo_full_in;

    always_comb begin
        int unsigned idx;
        idx       = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (!win_found && req_valid_in[idx]) begin
                win_found = 1'b1;
                win_idx   = IW'(idx);
            end
        end
    end

`ifdef FIFO_ARB_BURST_EN
    localparam int CW = $clog2(BURST_LEN + 1);

    typedef enum logic {IDLE, LOCK} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] lock_id_q, lock_id_d;
    logic [CW-1:0] beat_cnt_q, beat_cnt_d;

    always_comb begin
        cand_found = win_found;
        cand_idx   = win_idx;
        if (state_q == LOCK) begin
            cand_found = req_valid_in[lock_id_q];
            cand_idx   = lock_id_q;
        end
    end
`else
    always_comb begin
        cand_found = win_found;
        cand_idx   = win_idx;
    end
`endif

    assign accept        = cand_found && space_ok && !rst_in;
    assign req_ready_out = accept ? (NUM_REQ'(1) << cand_idx) : '0;

    always_comb begin
        wr_en_d  = 1'b0;
        data_d   = data_q;
        gid_d    = gid_q;
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            wr_en_d  = 1'b1;
            data_d   = req_data_in[int'(cand_idx)*WIDTH +: WIDTH];
            gid_d    = cand_idx;
            rr_ptr_d = ptr_inc(cand_idx);
        end
`ifdef FIFO_ARB_BURST_EN
        state_d    = state_q;
        lock_id_d  = lock_id_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (accept && BURST_LEN > 1) begin
                    state_d    = LOCK;
                    lock_id_d  = cand_idx;
                    beat_cnt_d = CW'(1);
                end
            end
            LOCK: begin
                // The pointer only moves when the lock is released.
                rr_ptr_d = rr_ptr_q;
                if (!req_valid_in[lock_id_q]) begin
                    state_d    = IDLE;
                    beat_cnt_d = '0;
                    rr_ptr_d   = ptr_inc(lock_id_q);
                end else if (accept) begin
                    if (beat_cnt_q == CW'(BURST_LEN - 1)) begin
                        state_d    = IDLE;
                        beat_cnt_d = '0;
                        rr_ptr_d   = ptr_inc(lock_id_q);
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
`endif
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wr_en_q  <= 1'b0;
            data_q   <= '0;
            gid_q    <= '0;
            rr_ptr_q <= '0;
        end else begin
            wr_en_q  <= wr_en_d;
            data_q   <= data_d;
            gid_q    <= gid_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

`ifdef FIFO_ARB_BURST_EN
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            lock_id_q  <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            lock_id_q  <= lock_id_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end
`endif

    assign fifo_wr_en_out  = wr_en_q;
    assign fifo_data_out   = data_q;
    assign grant_id_out    = gid_q;
    assign grant_valid_out = wr_en_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb/tb_fifo_write_arbiter.sv - directed table-driven bench for fifo_write_arbiter
module tb_fifo_write_arbiter;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [3:0]  req_valid_in;
    logic [31:0] req_data_in;
    logic [3:0]  req_ready_out;
    logic        fifo_wr_en_out;
    logic [7:0]  fifo_data_out;
    logic [3:0]  fifo_occupancy_in;
    logic        fifo_full_in;
    logic [1:0]  grant_id_out;
    logic        grant_valid_out;

    int n_cmp = 0;
    int n_bad = 0;
    int occ   = 0;
    int viol  = 0;

    fifo_write_arbiter #(.NUM_REQ(4), .WIDTH(8), .DEPTH(8), .BURST_LEN(4)) dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .req_valid_in      (req_valid_in),
        .req_data_in       (req_data_in),
        .req_ready_out     (req_ready_out),
        .fifo_wr_en_out    (fifo_wr_en_out),
        .fifo_data_out     (fifo_data_out),
        .fifo_occupancy_in (fifo_occupancy_in),
        .fifo_full_in      (fifo_full_in),
        .grant_id_out      (grant_id_out),
        .grant_valid_out   (grant_valid_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [3:0] valid;
        logic [3:0] occ;
        logic       full;
        logic [3:0] rdy;
        logic       wr;
        logic [7:0] data;
        logic [1:0] gid;
    } vec_t;

    vec_t vt [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
    endtask

    // One cycle against a FIFO whose occupancy follows writes and optional reads.
    task automatic fifo_cycle(input logic rd, output logic acc, output int occ_seen);
        int nxt;
        @(negedge clk_in);
        acc      = |req_ready_out;
        occ_seen = occ;
        if (fifo_wr_en_out && fifo_full_in) viol++;
        nxt = occ + int'(fifo_wr_en_out) - int'(rd);
        @(posedge clk_in);
        #1;
        occ               = nxt;
        fifo_occupancy_in = 4'(occ);
        fifo_full_in      = (occ == 8);
    endtask

    initial begin
        logic acc;
        int   acc_total;
        int   occ_seen;
        int   occ_at_acc;

        rst_in            = 1'b1;
        req_valid_in      = 4'b1111;
        req_data_in       = 32'hA3A2A1A0;
        fifo_occupancy_in = '0;
        fifo_full_in      = 1'b0;

        @(negedge clk_in);
        chk("rst_ready", req_ready_out, 0);
        chk("rst_wr_en", fifo_wr_en_out, 0);
        chk("rst_data", fifo_data_out, 0);
        chk("rst_gid", grant_id_out, 0);
        chk("rst_gvalid", grant_valid_out, 0);
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;

        //        valid    occ  full  rdy      wr    data   gid
        vt[0]  = '{4'b1111, 4'd0, 1'b0, 4'b0001, 1'b0, 8'h00, 2'd0};
        vt[1]  = '{4'b1111, 4'd0, 1'b0, 4'b0010, 1'b1, 8'hA0, 2'd0};
        vt[2]  = '{4'b1111, 4'd0, 1'b0, 4'b0100, 1'b1, 8'hA1, 2'd1};
        vt[3]  = '{4'b1111, 4'd0, 1'b0, 4'b1000, 1'b1, 8'hA2, 2'd2};
        vt[4]  = '{4'b1111, 4'd0, 1'b0, 4'b0001, 1'b1, 8'hA3, 2'd3};
        vt[5]  = '{4'b0000, 4'd0, 1'b0, 4'b0000, 1'b1, 8'hA0, 2'd0};
        vt[6]  = '{4'b0001, 4'd0, 1'b0, 4'b0001, 1'b0, 8'hA0, 2'd0};
        vt[7]  = '{4'b1100, 4'd7, 1'b0, 4'b0000, 1'b1, 8'hA0, 2'd0};
        vt[8]  = '{4'b1100, 4'd7, 1'b0, 4'b0100, 1'b0, 8'hA0, 2'd0};
        vt[9]  = '{4'b1100, 4'd6, 1'b0, 4'b1000, 1'b1, 8'hA2, 2'd2};
        vt[10] = '{4'b1100, 4'd0, 1'b1, 4'b0000, 1'b1, 8'hA3, 2'd3};
        vt[11] = '{4'b1010, 4'd8, 1'b0, 4'b0000, 1'b0, 8'hA3, 2'd3};
        vt[12] = '{4'b1010, 4'd5, 1'b0, 4'b0010, 1'b0, 8'hA3, 2'd3};
        vt[13] = '{4'b1010, 4'd5, 1'b0, 4'b1000, 1'b1, 8'hA1, 2'd1};
        vt[14] = '{4'b0000, 4'd0, 1'b0, 4'b0000, 1'b1, 8'hA3, 2'd3};

        for (int i = 0; i < 15; i++) begin
            req_valid_in      = vt[i].valid;
            fifo_occupancy_in = vt[i].occ;
            fifo_full_in      = vt[i].full;
            @(negedge clk_in);
            chk($sformatf("v%0d_ready", i), req_ready_out, vt[i].rdy);
            chk($sformatf("v%0d_wr_en", i), fifo_wr_en_out, vt[i].wr);
            chk($sformatf("v%0d_gvalid", i), grant_valid_out, vt[i].wr);
            chk($sformatf("v%0d_data", i), fifo_data_out, vt[i].data);
            chk($sformatf("v%0d_gid", i), grant_id_out, vt[i].gid);
            @(posedge clk_in);
            #1;
        end

        // Fill an empty FIFO from requester 2 alone, then free one slot.
        req_valid_in      = 4'b0000;
        occ               = 0;
        fifo_occupancy_in = '0;
        fifo_full_in      = 1'b0;
        do_reset();
        req_valid_in = 4'b0100;
        viol         = 0;
        acc_total    = 0;
        for (int i = 0; i < 12; i++) begin
            fifo_cycle(1'b0, acc, occ_seen);
            acc_total += int'(acc);
        end
        chk("fill_accepts", acc_total, 8);
        chk("fill_occ", occ, 8);
        chk("fill_full", fifo_full_in, 1);
        chk("fill_ready_after", req_ready_out, 0);
        chk("fill_gid", grant_id_out, 2);
        fifo_cycle(1'b1, acc, occ_seen);
        acc_total  = int'(acc);
        occ_at_acc = -1;
        for (int i = 0; i < 6; i++) begin
            fifo_cycle(1'b0, acc, occ_seen);
            if (acc) begin
                acc_total++;
                occ_at_acc = occ_seen;
            end
        end
        chk("read_accepts", acc_total, 1);
        chk("read_accept_occ", occ_at_acc, 7);
        chk("read_refull", occ, 8);
        chk("no_wr_while_full", viol, 0);

        // Asynchronous reset between edges while all requesters are active.
        occ               = 0;
        fifo_occupancy_in = '0;
        fifo_full_in      = 1'b0;
        req_valid_in      = 4'b1111;
        do_reset();
        @(posedge clk_in);
        @(posedge clk_in);
        @(negedge clk_in);
        #1 rst_in = 1'b1;
        #1;
        chk("arst_ready", req_ready_out, 0);
        chk("arst_wr_en", fifo_wr_en_out, 0);
        chk("arst_data", fifo_data_out, 0);
        chk("arst_gid", grant_id_out, 0);
        chk("arst_gvalid", grant_valid_out, 0);
        #1 rst_in = 1'b0;
        #1;
        chk("arst_first_ready", req_ready_out, 4'b0001);
        @(posedge clk_in);
        #1;
        chk("arst_first_wr", fifo_wr_en_out, 1);
        chk("arst_first_gid", grant_id_out, 0);
        chk("arst_first_data", fifo_data_out, 8'hA0);

`ifdef FIFO_ARB_BURST_EN
        begin
            logic [3:0] bexp [9];
            bexp = '{4'b0001, 4'b0001, 4'b0001, 4'b0001,
                     4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0001};
            req_valid_in = 4'b0000;
            do_reset();
            req_valid_in = 4'b0011;
            for (int i = 0; i < 9; i++) begin
                @(negedge clk_in);
                chk($sformatf("burst_ready%0d", i), req_ready_out, bexp[i]);
                @(posedge clk_in);
                #1;
            end

            req_valid_in = 4'b0000;
            do_reset();
            req_valid_in = 4'b1000;
            for (int i = 0; i < 2; i++) begin
                @(negedge clk_in);
                chk($sformatf("drop_ready%0d", i), req_ready_out, 4'b1000);
                @(posedge clk_in);
                #1;
            end
            req_valid_in = 4'b0110;
            acc_total    = 0;
            for (int i = 0; i < 3 && acc_total == 0; i++) begin
                @(negedge clk_in);
                if (req_ready_out != 4'b0000) begin
                    acc_total = 1;
                    chk("drop_next_grant", req_ready_out, 4'b0010);
                end
                @(posedge clk_in);
                #1;
            end
            chk("drop_grant_seen", acc_total, 1);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
